pos_cache_particle_reader: RTL and testbench
============================================

Name: pos_cache_particle_reader

Overview:
- Downstream consumer of a double-buffered position cache, which has a 1-cycle read latency and stores the particle count at address 0.
- On start, reads the count at address 0, then streams every particle record at addresses 1..N to the force-evaluation pipeline through a valid/ready handshake.
- Holds up to 2 records so that back-pressure never drops data.
- Sustains 1 particle/cycle while the consumer is ready.

Parameters:
- DATA_WIDTH, 96, width of a cache record ({posz,posy,posx}).
- ADDR_WIDTH, 8, cache address width.
- PARTICLE_NUM, 220, maximum legal particle count; larger counts are clamped to this value.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  begin one read pass; sampled only in IDLE
- cache_rden  out  1  read enable to the cache
- cache_rd_address  out  ADDR_WIDTH  read address to the cache
- cache_rd_data  in  DATA_WIDTH  cache read data, valid the cycle after cache_rden
- out_data  out  DATA_WIDTH  particle record
- out_particle_id  out  ADDR_WIDTH  cache address of the record (1..N)
- out_valid  out  1  record valid
- out_ready  in  1  consumer accepts the record
- out_last  out  1  marks the final record; qualified by out_valid
- particle_count  out  ADDR_WIDTH  clamped N, held until the next start
- busy  out  1  high from the start acceptance edge until done
- done  out  1  single-cycle pulse at the end of a pass

Behaviour:
- Reset: rst (synchronous, active-high) on clk. All outputs are 0, the buffer is empty, no read is in flight, and state is IDLE. Reset mid-pass aborts immediately; no done pulse is produced.
- Handshake: a transfer occurs when out_valid && out_ready. While out_valid=1 and out_ready=0, out_data, out_particle_id and out_last are held stable.
- FSM states: IDLE, RD_NUM, WAIT_NUM, STREAM, DONE.
  - IDLE: when start=1, go to RD_NUM and set busy=1. While not in IDLE, start is ignored.
  - RD_NUM: drive cache_rden=1 and cache_rd_address=0 for one cycle, then go to WAIT_NUM.
  - WAIT_NUM: capture cache_rd_data[ADDR_WIDTH-1:0] as raw; N = min(raw, PARTICLE_NUM). Load particle_count=N and next_addr=1. If N=0, go to DONE; otherwise go to STREAM.
  - STREAM:
    - Issue condition: next_addr ≤ N && (occ + inflight − pop) < 2, where occ = buffer occupancy (0..2), inflight = read issued in the previous cycle, pop = transfer this cycle.
    - On issue: cache_rden=1, cache_rd_address=next_addr, next_addr++.
    - No issue: cache_rden=0 and cache_rd_address holds its last value.
    - Returning data is written into the 2-entry FIFO together with its id. The FIFO head drives out_data and out_particle_id.
    - out_last=1 when the head id equals N.
    - Go to DONE on the transfer of the last record.
  - DONE: done=1 for one cycle, busy drops to 0 on the same edge, then go to IDLE.
- Latency with out_ready=1 and start=1 in cycle 0:
  - cycle 1: rden with address 0
  - cycle 2: count captured
  - cycle 3: address 1 issued
  - cycle 4: data on cache_rd_data
  - cycle 5: out_valid=1 with id 1
  - Records with ids 2..N follow, one per cycle.
  - done is high in the cycle after the last transfer.
- Full rate: with out_ready=1 the issue condition holds every cycle, so there are no bubbles.
- Back-pressure: with out_ready=0, at most 2 records are held and issuing stops. When out_ready returns, issuing resumes without loss or duplication, and ids stay strictly increasing.
- Arithmetic:
  - next_addr is ADDR_WIDTH+1 bits wide so that N = 2^ADDR_WIDTH−1 terminates without wrap.
  - Upper bits of the count word are ignored.
  - The cache is never addressed above N.
- Simultaneous events:
  - A FIFO push and pop in the same cycle keep occ unchanged.
  - A start that coincides with the done cycle is ignored.

Test Plan:
- Count word 3, out_ready=1, start pulse in cycle 0 -> rden with address 0 in cycle 1; addresses 1,2,3 in cycles 3,4,5; out_valid in cycles 5–7 with ids 1,2,3; out_last only in cycle 7; done in cycle 8; particle_count=3.
- Count 0 -> out_valid never asserted; done in cycle 3; only address 0 is read.
- Count 10 with out_ready toggling (1,0,0,1,0,1,...) -> exactly 10 transfers with ids 1..10 in order; records stable while stalled; occ never exceeds 2; no address above 10 is issued.
- Count word 0x12C, ADDR_WIDTH=9, PARTICLE_NUM=220 -> particle_count=220; last id 220; no read above 220.
- Start re-asserted during STREAM and during DONE -> ignored; a second start after IDLE runs a fresh pass beginning at address 0.
- rst asserted mid-STREAM, with 2 records buffered -> next cycle out_valid=0, busy=0, cache_rden=0, no done pulse; a subsequent start behaves like the first pass.

Source files
------------

// File: rtl/pos_cache_particle_reader.sv
// Position-cache particle reader.
// Reads the particle count stored at cache address 0, then streams records
// 1..N to the force pipeline over valid/ready. A 2-entry skid FIFO absorbs the
// one-cycle cache latency so back-pressure never loses a record, and the read
// issue logic keeps exactly enough reads in flight for one record per cycle.
module pos_cache_particle_reader #(
    parameter int DATA_WIDTH   = 96,
    parameter int ADDR_WIDTH   = 8,
    parameter int PARTICLE_NUM = 220
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  cache_rden,
    output logic [ADDR_WIDTH-1:0] cache_rd_address,
    input  logic [DATA_WIDTH-1:0] cache_rd_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_particle_id,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [ADDR_WIDTH-1:0] particle_count,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_NUM,
        S_WAIT_NUM,
        S_STREAM,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    // next_addr is one bit wider than the cache address so that a count of
    // 2^ADDR_WIDTH-1 can step past the last record without wrapping to 0.
    logic [ADDR_WIDTH:0]   next_addr_q, next_addr_d;
    logic [ADDR_WIDTH-1:0] count_q, count_d;
    // Last address driven to the cache; also the id of the read in flight.
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            occ_q, occ_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic                  wr_ptr_q, wr_ptr_d;

    logic [DATA_WIDTH-1:0] fifo_data_q [2];
    logic [ADDR_WIDTH-1:0] fifo_id_q   [2];

    logic                  push;
    logic                  pop;
    logic                  issue;
    logic [2:0]            occ_after;
    logic [ADDR_WIDTH-1:0] head_id;
    logic [ADDR_WIDTH-1:0] clamped_count;

    // Limit the count word to the largest particle population the pipeline supports.
    function automatic logic [ADDR_WIDTH-1:0] clamp_count(input logic [ADDR_WIDTH-1:0] raw);
        if (32'(raw) > 32'(PARTICLE_NUM)) begin
            return ADDR_WIDTH'(PARTICLE_NUM);
        end
        return raw;
    endfunction

    assign clamped_count = clamp_count(cache_rd_data[ADDR_WIDTH-1:0]);

    // Head of the FIFO drives the stream; payload is zeroed while nothing is valid.
    assign out_valid       = (occ_q != 2'd0);
    assign head_id         = fifo_id_q[rd_ptr_q];
    assign out_data        = out_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign out_particle_id = out_valid ? head_id : '0;
    assign out_last        = out_valid && (head_id == count_q);
    assign particle_count  = count_q;

    assign pop  = out_valid && out_ready;
    // Data returns one cycle after an issue; only stream reads carry records.
    assign push = inflight_q && (state_q == S_STREAM);

    // Occupancy the FIFO would have once the read in flight lands and this
    // cycle's transfer leaves; a new read is allowed only if it still fits.
    assign occ_after = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
    assign issue     = (state_q == S_STREAM) &&
                       (next_addr_q <= {1'b0, count_q}) &&
                       (occ_after < 3'd2);

    // Next-state, cache-read and FIFO bookkeeping for the read pass.
    always_comb begin
        state_d          = state_q;
        next_addr_d      = next_addr_q;
        count_d          = count_q;
        inflight_d       = 1'b0;
        cache_rden       = 1'b0;
        cache_rd_address = addr_q;
        busy             = 1'b0;
        done             = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RD_NUM;
                end
            end
            S_RD_NUM: begin
                busy             = 1'b1;
                cache_rden       = 1'b1;
                cache_rd_address = '0;
                state_d          = S_WAIT_NUM;
            end
            S_WAIT_NUM: begin
                busy        = 1'b1;
                count_d     = clamped_count;
                next_addr_d = (ADDR_WIDTH+1)'(1);
                if (clamped_count == '0) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                busy = 1'b1;
                if (issue) begin
                    cache_rden       = 1'b1;
                    cache_rd_address = next_addr_q[ADDR_WIDTH-1:0];
                    next_addr_d      = next_addr_q + (ADDR_WIDTH+1)'(1);
                    inflight_d       = 1'b1;
                end
                if (pop && out_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        addr_d   = cache_rd_address;
        occ_d    = occ_q + 2'(push) - 2'(pop);
        rd_ptr_d = rd_ptr_q ^ pop;
        wr_ptr_d = wr_ptr_q ^ push;
    end

    // Control state; reset aborts any pass and empties the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            next_addr_q <= '0;
            count_q     <= '0;
            addr_q      <= '0;
            inflight_q  <= 1'b0;
            occ_q       <= 2'd0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            next_addr_q <= next_addr_d;
            count_q     <= count_d;
            addr_q      <= addr_d;
            inflight_q  <= inflight_d;
            occ_q       <= occ_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
        end
    end

    // FIFO storage: returning record and its address written at the tail.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= cache_rd_data;
            fifo_id_q[wr_ptr_q]   <= addr_q;
        end
    end

endmodule

// File: tb/tb_pos_cache_particle_reader.sv
// Bench for pos_cache_particle_reader: behavioural cache memory, expected
// record queue derived from the count word, and a per-cycle monitor.
module tb_pos_cache_particle_reader;

    localparam int DW = 96;
    localparam int AW = 9;
    localparam int PN = 220;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          cache_rden;
    logic [AW-1:0] cache_rd_address;
    logic [DW-1:0] cache_rd_data = '0;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_particle_id;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic [AW-1:0] particle_count;
    logic          busy;
    logic          done;

    pos_cache_particle_reader #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .PARTICLE_NUM(PN)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .cache_rden      (cache_rden),
        .cache_rd_address(cache_rd_address),
        .cache_rd_data   (cache_rd_data),
        .out_data        (out_data),
        .out_particle_id (out_particle_id),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_last        (out_last),
        .particle_count  (particle_count),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Cache: one-cycle read latency.
    logic [DW-1:0] mem [512];
    always @(posedge clk) begin
        if (cache_rden) cache_rd_data <= mem[cache_rd_address];
    end

    // Reference model state for the current pass.
    bit       mon_en = 1'b0;
    int       n_model;
    int       exp_ids[$];
    int       exp_addr;
    int       issued;
    int       xfers;
    int       done_seen;
    bit       prev_stall;
    logic [DW-1:0] prev_data;
    logic [AW-1:0] prev_id;
    logic          prev_last;

    task automatic setup_model(input logic [DW-1:0] word);
        int raw;
        mem[0] = word;
        for (int i = 1; i < 512; i++) mem[i] = {$urandom, $urandom, $urandom};
        raw = int'(word[AW-1:0]);
        n_model = (raw > PN) ? PN : raw;
        exp_ids = {};
        for (int i = 1; i <= n_model; i++) exp_ids.push_back(i);
        exp_addr   = 0;
        issued     = 0;
        xfers      = 0;
        done_seen  = 0;
        prev_stall = 1'b0;
        mon_en     = 1'b1;
    endtask

    // Per-cycle monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        if (mon_en) begin
            int id;
            if (cache_rden) begin
                check("rd_addr_seq", cache_rd_address, exp_addr);
                check("rd_addr_le_n", cache_rd_address <= n_model, 1'b1);
                if (exp_addr > 0) issued++;
                exp_addr++;
            end
            if (prev_stall) begin
                check("stall_valid", out_valid, 1'b1);
                check("stall_data", out_data, prev_data);
                check("stall_id", out_particle_id, prev_id);
                check("stall_last", out_last, prev_last);
            end
            check("extra_valid", out_valid && (exp_ids.size() == 0), 1'b0);
            if (out_valid && out_ready) begin
                check("xfer_expected", exp_ids.size() > 0, 1'b1);
                if (exp_ids.size() > 0) begin
                    id = exp_ids.pop_front();
                    check("xfer_id", out_particle_id, id);
                    check("xfer_data", out_data, mem[id]);
                    check("xfer_last", out_last, id == n_model);
                end
                xfers++;
            end
            check("outstanding_le2", (issued - xfers) <= 2, 1'b1);
            if (done) done_seen++;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_id    = out_particle_id;
            prev_last  = out_last;
        end
    end

    function automatic logic rdy(input int mode, input int cyc);
        case (mode)
            0:       return 1'b1;
            1:       return (cyc % 6 == 0) || (cyc % 6 == 3) || (cyc % 6 == 5);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // One pass: start in cycle 0, drive out_ready by mode, optionally poke
    // start mid-pass and in the done cycle, optionally check exact latency.
    task automatic run_pass(input logic [DW-1:0] word, input int mode, input bit poke, input bit timed);
        bit got_done = 1'b0;
        int n;
        setup_model(word);
        n = n_model;
        @(posedge clk);
        #1 start = 1'b1;
        out_ready = rdy(mode, 0);
        for (int c = 1; c < 3000 && !got_done; c++) begin
            @(posedge clk);
            #1 start = poke && (c == 8);
            out_ready = rdy(mode, c);
            #1;
            if (timed) begin
                logic er, ev;
                er = (c == 1) || (c >= 3 && c <= n + 2);
                ev = (c >= 5) && (c <= n + 4);
                check("t_rden", cache_rden, er);
                if (er) check("t_addr", cache_rd_address, (c == 1) ? 0 : c - 2);
                check("t_valid", out_valid, ev);
                if (ev) begin
                    check("t_id", out_particle_id, c - 4);
                    check("t_last", out_last, c == n + 4);
                end
                check("t_done", done, c == ((n == 0) ? 3 : n + 5));
                if (c == 1) check("t_busy", busy, 1'b1);
            end
            if (done) begin
                got_done = 1'b1;
                if (poke) start = 1'b1;
            end
        end
        check("done_seen", got_done, 1'b1);
        @(posedge clk);
        #1 start = 1'b0;
        #1;
        check("idle_after_pass", busy, 1'b0);
        check("done_once", done_seen, 1);
        check("all_xfers", xfers, n);
        check("particle_count", particle_count, n);
        check("addr_span", exp_addr, n + 1);
        if (!got_done) begin
            $display("FAIL pass_timeout: got no done, expected done");
            $fatal(1, "pass did not complete");
        end
    endtask

    initial begin
        int seen;
        rst = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_rden", cache_rden, 1'b0);
        check("rst_addr", cache_rd_address, 0);
        check("rst_count", particle_count, 0);
        check("rst_data", out_data, 0);
        check("rst_id", out_particle_id, 0);
        check("rst_last", out_last, 1'b0);

        run_pass(96'd3, 0, 1'b0, 1'b1);
        run_pass(96'd0, 0, 1'b0, 1'b1);
        run_pass(96'd1, 0, 1'b0, 1'b1);
        run_pass(96'd10, 1, 1'b1, 1'b0);
        run_pass(96'h12C, 2, 1'b0, 1'b0);
        run_pass(96'h12C, 0, 1'b1, 1'b1);
        run_pass({$urandom, $urandom, 23'($urandom), 9'd17}, 2, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            run_pass({$urandom, $urandom, 23'($urandom), 9'($urandom_range(0, 40))},
                     int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'b0);
        end

        // Abort mid-stream with two records held.
        setup_model(96'd10);
        @(posedge clk);
        #1 start = 1'b1;
        out_ready = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1 start = 1'b0;
        end
        #1;
        check("prerst_valid", out_valid, 1'b1);
        check("prerst_held", issued - xfers, 2);
        mon_en = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("postrst_valid", out_valid, 1'b0);
        check("postrst_busy", busy, 1'b0);
        check("postrst_rden", cache_rden, 1'b0);
        check("postrst_done", done, 1'b0);
        seen = 0;
        repeat (10) begin
            @(posedge clk);
            #2 if (done) seen++;
        end
        check("postrst_no_done", seen, 0);

        run_pass(96'd3, 0, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
